rr_arbiter4: RTL and testbench

RR_ARBITER4 -- requirements
Module: rr_arbiter4

---
 rtl/arb_pkg.sv | 10 +
 rtl/rr_arbiter4_if.sv | 13 +
 rtl/rr_arbiter4_grant_decoder.sv | 15 +
 rtl/rr_arbiter4.sv | 89 ++++++++
 tb/tb_rr_arbiter4.sv | 353 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/arb_pkg.sv
// Shared types and sizes for the four-way round-robin arbiter.
package arb_pkg;
  localparam int NUM_REQ = 4;
  localparam int IDX_W   = 2;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;
endpackage

// File: rtl/rr_arbiter4_if.sv
// Request/grant bundle between the requesters and the arbiter.
interface rr_arbiter4_if;
  import arb_pkg::*;

  logic [NUM_REQ-1:0] req;
  logic               done;
  logic [NUM_REQ-1:0] gnt;
  logic [IDX_W-1:0]   gnt_id;
  logic               busy;

  modport master (output req, done, input gnt, gnt_id, busy);
  modport slave  (input req, done, output gnt, gnt_id, busy);
endinterface

// File: rtl/rr_arbiter4_grant_decoder.sv
// Binary index to one-hot grant vector; all-zero when not enabled.
module grant_decoder
  import arb_pkg::*;
(
  input  logic [IDX_W-1:0]   i_id,
  input  logic               i_en,
  output logic [NUM_REQ-1:0] o_onehot
);

  always_comb begin
    o_onehot = '0;
    if (i_en) o_onehot[i_id] = 1'b1;
  end

endmodule

// File: rtl/rr_arbiter4.sv
// Four-way round-robin arbiter with optional grant hold limit; grant appears one
// edge after a request is seen in IDLE, and every release leaves one dead cycle.
module rr_arbiter4
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 15
) (
  input  logic          clk,
  input  logic          rst_n,
  rr_arbiter4_if.slave  bus
);

  // At least one bit so MAX_HOLD=0 still yields a legal counter.
  localparam int CNT_W = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [CNT_W-1:0] HOLD_MAX  = CNT_W'(MAX_HOLD);
  localparam logic [CNT_W-1:0] HOLD_LAST = (MAX_HOLD == 0) ? CNT_W'(0) : CNT_W'(MAX_HOLD - 1);

  state_t               r_state;
  logic [IDX_W-1:0]     r_ptr;
  logic [IDX_W-1:0]     r_gnt_id;
  logic                 r_busy;
  logic [CNT_W-1:0]     r_hold;

  logic [IDX_W-1:0]     w_winner;
  logic                 w_any;
  logic                 w_hold_hit;
  logic                 w_release;
  logic [NUM_REQ-1:0]   w_gnt;

  // Scan from the slot after the last winner; k=NUM_REQ wraps back onto ptr itself.
  always_comb begin
    w_winner = r_ptr;
    w_any    = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!w_any && bus.req[r_ptr + IDX_W'(k)]) begin
        w_winner = r_ptr + IDX_W'(k);
        w_any    = 1'b1;
      end
    end
  end

  assign w_hold_hit = (MAX_HOLD != 0) && (r_hold == HOLD_LAST);
  assign w_release  = bus.done || !bus.req[r_gnt_id] || w_hold_hit;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_ptr    <= 2'b11;
      r_gnt_id <= '0;
      r_busy   <= 1'b0;
      r_hold   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_state  <= GRANT;
            r_busy   <= 1'b1;
            r_gnt_id <= w_winner;
            r_ptr    <= w_winner;
            r_hold   <= '0;
          end
        end
        GRANT: begin
          if (w_release) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else if (r_hold != HOLD_MAX) begin
            r_hold <= r_hold + CNT_W'(1);
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  grant_decoder u_dec (
    .i_id     (r_gnt_id),
    .i_en     (r_busy),
    .o_onehot (w_gnt)
  );

  assign bus.gnt    = w_gnt;
  assign bus.gnt_id = r_gnt_id;
  assign bus.busy   = r_busy;

endmodule

// File: tb/tb_rr_arbiter4.sv
// Bench for rr_arbiter4: default-limit and MAX_HOLD=3 instances share stimulus,
// each tracked by a cycle-level model of the arbitration rules.
module tb_rr_arbiter4;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic       done;

  int checks;
  int errors;
  bit mon_en;

  rr_arbiter4_if bus15 ();
  rr_arbiter4_if bus3 ();

  assign bus15.req  = req;
  assign bus15.done = done;
  assign bus3.req   = req;
  assign bus3.done  = done;

  rr_arbiter4 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus15.slave)
  );

  rr_arbiter4 #(.MAX_HOLD(3)) dut3 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus3.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit busy;
    int id;
    int ptr;
    int held;
  } mst_t;

  mst_t m15 = '{0, 0, 3, 0};
  mst_t m3  = '{0, 0, 3, 0};

  function automatic mst_t step(mst_t s, logic [3:0] r, logic d, logic rn, int maxh);
    mst_t n = s;
    if (!rn) begin
      n.busy = 0; n.id = 0; n.ptr = 3; n.held = 0;
    end else if (!s.busy) begin
      for (int k = 1; k <= 4; k++) begin
        int idx = (s.ptr + k) % 4;
        if (!n.busy && r[idx]) begin
          n.busy = 1; n.id = idx; n.ptr = idx; n.held = 0;
        end
      end
    end else begin
      // held counts grant cycles already completed; this is cycle held+1
      if (d || !r[s.id] || (maxh != 0 && s.held + 1 == maxh)) n.busy = 0;
      else n.held = s.held + 1;
    end
    return n;
  endfunction

  function automatic logic [3:0] exp_gnt(mst_t s);
    return s.busy ? 4'(1 << s.id) : 4'b0000;
  endfunction

  always @(posedge clk) begin
    m15 <= step(m15, req, done, rst_n, 15);
    m3  <= step(m3, req, done, rst_n, 3);
  end

  logic [3:0] mon_g;
  logic       mon_b;
  logic [1:0] mon_i;
  logic [3:0] mon_pg [2];
  logic       mon_pb [2];

  initial begin
    mon_pb[0] = 1'b0;
    mon_pb[1] = 1'b0;
    mon_pg[0] = 4'b0;
    mon_pg[1] = 4'b0;
  end

  // Continuous grant invariants on both instances.
  always @(negedge clk) begin
    if (mon_en) begin
      for (int u = 0; u < 2; u++) begin
        mon_g = (u == 0) ? bus15.gnt    : bus3.gnt;
        mon_b = (u == 0) ? bus15.busy   : bus3.busy;
        mon_i = (u == 0) ? bus15.gnt_id : bus3.gnt_id;
        checks++;
        if ((mon_g & (mon_g - 4'd1)) !== 4'b0000) begin
          errors++;
          $display("FAIL onehot u%0d gnt=%b must be one-hot or zero", u, mon_g);
        end
        checks++;
        if (mon_g !== (mon_b ? 4'(1 << mon_i) : 4'b0000)) begin
          errors++;
          $display("FAIL gnt_match u%0d gnt=%b busy=%b id=%0d", u, mon_g, mon_b, mon_i);
        end
        checks++;
        if (mon_pb[u] && mon_b && mon_g !== mon_pg[u]) begin
          errors++;
          $display("FAIL gnt_stable u%0d gnt=%b changed from %b mid-grant", u, mon_g, mon_pg[u]);
        end
        mon_pg[u] = mon_g;
        mon_pb[u] = mon_b;
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    cyc(1);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = 4'b1111; done = 1'b1;
    cyc(2);
    checks++;
    if (bus15.gnt !== 4'b0 || bus15.busy !== 1'b0 || bus15.gnt_id !== 2'b00) begin
      errors++;
      $display("FAIL reset15 gnt=%b busy=%b id=%b want 0000/0/00", bus15.gnt, bus15.busy, bus15.gnt_id);
    end
    checks++;
    if (bus3.gnt !== 4'b0 || bus3.busy !== 1'b0 || bus3.gnt_id !== 2'b00) begin
      errors++;
      $display("FAIL reset3 gnt=%b busy=%b id=%b want 0000/0/00", bus3.gnt, bus3.busy, bus3.gnt_id);
    end
    rst_n = 1'b1; req = 4'b0; done = 1'b0;
    mon_en = 1'b1;
    cyc(1);
    checks++;
    if (bus15.gnt !== 4'b0 || bus15.busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_noreq gnt=%b busy=%b want 0000/0", bus15.gnt, bus15.busy);
    end
  endtask

  task automatic test_rotation();
    logic [3:0] seq [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    apply_reset();
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      cyc(1);
      checks++;
      if (bus15.gnt !== seq[i] || bus15.busy !== 1'b1) begin
        errors++;
        $display("FAIL rotation grant%0d gnt=%b busy=%b want %b/1", i, bus15.gnt, bus15.busy, seq[i]);
      end
      done = 1'b1;
      cyc(1);
      done = 1'b0;
      checks++;
      if (bus15.gnt !== 4'b0 || bus15.busy !== 1'b0) begin
        errors++;
        $display("FAIL rotation dead%0d gnt=%b busy=%b want 0000/0", i, bus15.gnt, bus15.busy);
      end
    end
    req = 4'b0;
  endtask

  task automatic test_single_req();
    apply_reset();
    req = 4'b0; done = 1'b0;
    cyc(5);
    req = 4'b0100;
    cyc(1);
    checks++;
    if (bus15.gnt !== 4'b0100 || bus15.gnt_id !== 2'd2 || bus15.busy !== 1'b1) begin
      errors++;
      $display("FAIL single_grant gnt=%b id=%0d busy=%b want 0100/2/1", bus15.gnt, bus15.gnt_id, bus15.busy);
    end
    for (int c = 7; c <= 9; c++) begin
      cyc(1);
      checks++;
      if (bus15.gnt !== 4'b0100) begin
        errors++;
        $display("FAIL single_hold c%0d gnt=%b want 0100", c, bus15.gnt);
      end
    end
    req = 4'b0;
    cyc(1);
    checks++;
    if (bus15.gnt !== 4'b0 || bus15.busy !== 1'b0) begin
      errors++;
      $display("FAIL single_drop gnt=%b busy=%b want 0000/0", bus15.gnt, bus15.busy);
    end
  endtask

  task automatic test_max_hold();
    logic [3:0] want3;
    logic [3:0] want15;
    apply_reset();
    req = 4'b0011; done = 1'b0;
    for (int t = 0; t < 17; t++) begin
      cyc(1);
      case (t % 8)
        0, 1, 2: want3 = 4'b0001;
        4, 5, 6: want3 = 4'b0010;
        default: want3 = 4'b0000;
      endcase
      want15 = (t < 15) ? 4'b0001 : (t == 15) ? 4'b0000 : 4'b0010;
      checks++;
      if (bus3.gnt !== want3) begin
        errors++;
        $display("FAIL maxhold3 t%0d gnt=%b want %b", t, bus3.gnt, want3);
      end
      checks++;
      if (bus15.gnt !== want15) begin
        errors++;
        $display("FAIL maxhold15 t%0d gnt=%b want %b", t, bus15.gnt, want15);
      end
    end
    req = 4'b0;
  endtask

  task automatic test_reset_mid_grant();
    apply_reset();
    req = 4'b1000;
    cyc(2);
    checks++;
    if (bus15.gnt !== 4'b1000) begin
      errors++;
      $display("FAIL midrst_pre gnt=%b want 1000", bus15.gnt);
    end
    rst_n = 1'b0;
    cyc(1);
    checks++;
    if (bus15.gnt !== 4'b0 || bus15.busy !== 1'b0 || bus15.gnt_id !== 2'b00) begin
      errors++;
      $display("FAIL midrst_drop gnt=%b busy=%b id=%b want 0000/0/00", bus15.gnt, bus15.busy, bus15.gnt_id);
    end
    rst_n = 1'b1; req = 4'b1001;
    cyc(1);
    checks++;
    if (bus15.gnt !== 4'b0001) begin
      errors++;
      $display("FAIL midrst_first gnt=%b want 0001", bus15.gnt);
    end
    // Leave ptr at 1, then show reset returns priority to requester 0's side.
    done = 1'b1;
    cyc(1);
    done = 1'b0; req = 4'b0010;
    cyc(1);
    req = 4'b0110; rst_n = 1'b0;
    cyc(1);
    rst_n = 1'b1;
    cyc(1);
    checks++;
    if (bus15.gnt !== 4'b0010) begin
      errors++;
      $display("FAIL midrst_ptr gnt=%b want 0010", bus15.gnt);
    end
    req = 4'b0;
    cyc(2);
  endtask

  task automatic test_simul_release();
    apply_reset();
    req = 4'b0010;
    cyc(1);
    checks++;
    if (bus15.gnt !== 4'b0010 || bus15.gnt_id !== 2'd1) begin
      errors++;
      $display("FAIL simul_grant gnt=%b id=%0d want 0010/1", bus15.gnt, bus15.gnt_id);
    end
    req = 4'b0110;
    for (int i = 0; i < 2; i++) begin
      cyc(1);
      checks++;
      if (bus15.gnt !== 4'b0010) begin
        errors++;
        $display("FAIL simul_ignore%0d gnt=%b want 0010", i, bus15.gnt);
      end
    end
    req = 4'b0100; done = 1'b1;
    cyc(1);
    done = 1'b0;
    checks++;
    if (bus15.gnt !== 4'b0 || bus15.busy !== 1'b0) begin
      errors++;
      $display("FAIL simul_release gnt=%b busy=%b want 0000/0", bus15.gnt, bus15.busy);
    end
    for (int i = 0; i < 2; i++) begin
      cyc(1);
      checks++;
      if (bus15.gnt !== 4'b0100 || bus15.gnt_id !== 2'd2 || bus15.busy !== 1'b1) begin
        errors++;
        $display("FAIL simul_next%0d gnt=%b id=%0d busy=%b want 0100/2/1", i, bus15.gnt, bus15.gnt_id, bus15.busy);
      end
    end
    req = 4'b0;
    cyc(1);
  endtask

  task automatic test_random();
    apply_reset();
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
      done  = ($urandom_range(0, 5) == 0);
      rst_n = ($urandom_range(0, 99) != 0);
      cyc(1);
      checks++;
      if (bus15.gnt !== exp_gnt(m15) || bus15.busy !== m15.busy ||
          (m15.busy && bus15.gnt_id !== 2'(m15.id))) begin
        errors++;
        $display("FAIL rand15 c%0d gnt=%b busy=%b id=%0d want %b/%0d/%0d",
                 c, bus15.gnt, bus15.busy, bus15.gnt_id, exp_gnt(m15), m15.busy, m15.id);
      end
      checks++;
      if (bus3.gnt !== exp_gnt(m3) || bus3.busy !== m3.busy ||
          (m3.busy && bus3.gnt_id !== 2'(m3.id))) begin
        errors++;
        $display("FAIL rand3 c%0d gnt=%b busy=%b id=%0d want %b/%0d/%0d",
                 c, bus3.gnt, bus3.busy, bus3.gnt_id, exp_gnt(m3), m3.busy, m3.id);
      end
    end
    rst_n = 1'b1; req = 4'b0; done = 1'b0;
    cyc(2);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    mon_en = 1'b0;
    rst_n  = 1'b0;
    req    = 4'b0;
    done   = 1'b0;
    test_reset();
    test_rotation();
    test_single_req();
    test_max_hold();
    test_reset_mid_grant();
    test_simul_release();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
